// File: rtl/instr_type_pkg.sv
`default_nettype none
// ============================================================================
// Module      : instr_type (package)
// Description : Shared load-kind encoding, load unit FSM states and
//               exception cause codes.
// Revision    : 1.0
// ============================================================================
package instr_type;

    typedef enum logic [2:0] {
        lk_invalid = 3'd0,
        lk_lb      = 3'd1,
        lk_lh      = 3'd2,
        lk_lw      = 3'd3,
        lk_lbu     = 3'd4,
        lk_lhu     = 3'd5
    } load_kind_t;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_REQ  = 3'd1,
        ST_WAIT = 3'd2,
        ST_WB   = 3'd3,
        ST_EXC  = 3'd4
    } load_state_t;

    localparam logic [1:0] c_exc_illegal    = 2'd0;
    localparam logic [1:0] c_exc_misaligned = 2'd1;

    function automatic logic kind_is_legal(input load_kind_t kind);
        return kind inside {lk_lb, lk_lh, lk_lw, lk_lbu, lk_lhu};
    endfunction

endpackage
`default_nettype wire

// File: rtl/load_extract.sv
`default_nettype none
// ============================================================================
// Module      : load_extract
// Description : Selects the byte/halfword lane of a memory word and
//               sign- or zero-extends it according to the load kind.
// Revision    : 1.0
// ============================================================================
module load_extract
    import instr_type::*;
(
    input  load_kind_t  kind,
    input  logic [1:0]  addr,
    input  logic [31:0] word,
    output logic [31:0] result
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        w_byte = word[7:0];
        case (addr)
            2'd0: w_byte = word[7:0];
            2'd1: w_byte = word[15:8];
            2'd2: w_byte = word[23:16];
            2'd3: w_byte = word[31:24];
            default: w_byte = word[7:0];
        endcase
        // Halfword lane uses addr[1] only, so a stray addr[0] folds onto lane 0/1.
        w_half = addr[1] ? word[31:16] : word[15:0];

        result = '0;
        case (kind)
            lk_lb:   result = {{24{w_byte[7]}}, w_byte};
            lk_lbu:  result = {24'd0, w_byte};
            lk_lh:   result = {{16{w_half[15]}}, w_half};
            lk_lhu:  result = {16'd0, w_half};
            lk_lw:   result = word;
            default: result = '0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/load_unit.sv
`default_nettype none
// ============================================================================
// Module      : load_unit
// Description : Single-outstanding load unit: request, wait, extend,
//               writeback. LOAD_MISALIGN_TRAP_EN enables misalignment traps.
// Revision    : 1.0
// ============================================================================
module load_unit
    import instr_type::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  load_kind_t  in_kind,
    input  logic [31:0] in_addr,
    input  logic [4:0]  in_rd,
    output logic        mem_req_valid,
    input  logic        mem_req_ready,
    output logic [31:0] mem_addr,
    input  logic        mem_resp_valid,
    input  logic [31:0] mem_rdata,
    output logic        wb_valid,
    input  logic        wb_ready,
    output logic [4:0]  wb_rd,
    output logic [31:0] wb_data,
    output logic        exc_valid,
    output logic [1:0]  exc_cause
);

    load_state_t state_q, state_d;
    logic        alive_q, alive_d;
    load_kind_t  kind_q, kind_d;
    logic [31:0] addr_q, addr_d;
    logic [4:0]  rd_q, rd_d;
    logic [31:0] data_q, data_d;
    logic [1:0]  cause_q, cause_d;

    logic        w_accept;
    logic        w_legal;
    logic        w_misaligned;
    logic [31:0] w_ext_result;

    assign w_accept = (state_q == ST_IDLE) && alive_q && in_valid;
    assign w_legal  = kind_is_legal(in_kind);

`ifdef LOAD_MISALIGN_TRAP_EN
    assign w_misaligned = (((in_kind == lk_lh) || (in_kind == lk_lhu)) && in_addr[0])
                        || ((in_kind == lk_lw) && (in_addr[1:0] != 2'b00));
`else
    assign w_misaligned = 1'b0;
`endif

    load_extract u_extract (
        .kind   (kind_q),
        .addr   (addr_q[1:0]),
        .word   (mem_rdata),
        .result (w_ext_result)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (w_accept) begin
                    state_d = (!w_legal || w_misaligned) ? ST_EXC : ST_REQ;
                end
            end
            ST_REQ:  if (mem_req_ready)  state_d = ST_WAIT;
            ST_WAIT: if (mem_resp_valid) state_d = ST_WB;
            ST_WB:   if (wb_ready)       state_d = ST_IDLE;
            ST_EXC:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // alive_q keeps in_ready low until the first edge after reset release.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            alive_q <= 1'b0;
            kind_q  <= lk_invalid;
            addr_q  <= '0;
            rd_q    <= '0;
            data_q  <= '0;
            cause_q <= '0;
        end else begin
            alive_q <= alive_d;
            kind_q  <= kind_d;
            addr_q  <= addr_d;
            rd_q    <= rd_d;
            data_q  <= data_d;
            cause_q <= cause_d;
        end
    end

    always_comb begin
        alive_d = 1'b1;
        kind_d  = kind_q;
        addr_d  = addr_q;
        rd_d    = rd_q;
        data_d  = data_q;
        cause_d = cause_q;
        if (w_accept) begin
            kind_d  = in_kind;
            addr_d  = in_addr;
            rd_d    = in_rd;
            cause_d = w_legal ? c_exc_misaligned : c_exc_illegal;
        end
        if ((state_q == ST_WAIT) && mem_resp_valid) begin
            data_d = w_ext_result;
        end
    end

    always_comb begin
        in_ready      = (state_q == ST_IDLE) && alive_q;
        mem_req_valid = (state_q == ST_REQ);
        mem_addr      = (state_q == ST_REQ) ? {addr_q[31:2], 2'b00} : 32'd0;
        wb_valid      = (state_q == ST_WB);
        wb_rd         = rd_q;
        wb_data       = data_q;
        exc_valid     = (state_q == ST_EXC);
        exc_cause     = (state_q == ST_EXC) ? cause_q : 2'd0;
    end

endmodule
`default_nettype wire

// File: tb/tb_load_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_load_unit
// Description : Self-checking bench for load_unit against a behavioural
//               load model (directed scenarios plus randomized loads).
// Revision    : 1.0
// ============================================================================
module tb_load_unit;
    import instr_type::*;

`ifdef LOAD_MISALIGN_TRAP_EN
    localparam bit TRAP_EN = 1'b1;
`else
    localparam bit TRAP_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    load_kind_t  in_kind = lk_invalid;
    logic [31:0] in_addr = '0;
    logic [4:0]  in_rd = '0;
    logic        mem_req_valid;
    logic        mem_req_ready = 1'b0;
    logic [31:0] mem_addr;
    logic        mem_resp_valid = 1'b0;
    logic [31:0] mem_rdata = '0;
    logic        wb_valid;
    logic        wb_ready = 1'b0;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        exc_valid;
    logic [1:0]  exc_cause;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    load_unit dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_kind(in_kind),
        .in_addr(in_addr), .in_rd(in_rd),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
        .mem_addr(mem_addr), .mem_resp_valid(mem_resp_valid), .mem_rdata(mem_rdata),
        .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_rd(wb_rd), .wb_data(wb_data),
        .exc_valid(exc_valid), .exc_cause(exc_cause)
    );

    // Observations of one transaction, filled by run_load.
    int          o_ready0, o_req_seen, o_req_cycle, o_wb_seen, o_wb_cycle, o_wb_cnt;
    int          o_exc_cnt, o_exc_cycle, o_ready_cycle;
    logic [31:0] o_addr, o_data;
    logic [4:0]  o_rd;
    logic [1:0]  o_cause;
    bit          o_unstable, o_cause_bad, o_timeout;

    function automatic logic [31:0] ref_data(input load_kind_t k, input logic [31:0] a,
                                             input logic [31:0] w);
        logic [31:0] v;
        int lane_b, lane_h;
        lane_b = int'(a % 4);
        lane_h = int'((a / 2) % 2);
        case (k)
            lk_lb, lk_lbu: begin
                v = (w >> (8 * lane_b)) & 32'hFF;
                if (k == lk_lb && v >= 32'd128) v = v + 32'hFFFF_FF00;
            end
            lk_lh, lk_lhu: begin
                v = (w >> (16 * lane_h)) & 32'hFFFF;
                if (k == lk_lh && v >= 32'd32768) v = v + 32'hFFFF_0000;
            end
            default: v = w;
        endcase
        return v;
    endfunction

    function automatic bit ref_misaligned(input load_kind_t k, input logic [31:0] a);
        return ((k == lk_lh || k == lk_lhu) && (a % 2 != 0)) || (k == lk_lw && (a % 4 != 0));
    endfunction

    task automatic run_load(input load_kind_t k, input logic [31:0] a, input logic [4:0] rd,
                            input logic [31:0] w, input int req_stall, input int resp_delay,
                            input int wb_stall);
        bit waiting;
        bit acc;
        int cd;
        waiting = 0; cd = 0;
        o_req_seen = 0; o_req_cycle = -1; o_wb_seen = 0; o_wb_cycle = -1; o_wb_cnt = 0;
        o_exc_cnt = 0; o_exc_cycle = -1; o_ready_cycle = -1;
        o_addr = '0; o_data = '0; o_rd = '0; o_cause = '0;
        o_unstable = 0; o_cause_bad = 0; o_timeout = 0;
        @(negedge clk);
        o_ready0 = int'(in_ready);
        in_valid = 1'b1; in_kind = k; in_addr = a; in_rd = rd;
        mem_req_ready  = 1'($urandom_range(0, 1));
        mem_resp_valid = 1'($urandom_range(0, 1));
        mem_rdata      = $urandom;
        wb_ready       = 1'($urandom_range(0, 1));
        for (int cyc = 1; cyc <= 200; cyc++) begin
            @(negedge clk);
            if (in_ready) begin
                o_ready_cycle = cyc;
                break;
            end
            // Offer noise on the input side while busy; it must be ignored.
            in_valid = 1'($urandom_range(0, 1));
            in_kind  = load_kind_t'(3'($urandom_range(0, 5)));
            in_addr  = $urandom;
            in_rd    = 5'($urandom);
            if (exc_valid) begin
                o_exc_cnt++;
                if (o_exc_cnt == 1) begin
                    o_exc_cycle = cyc;
                    o_cause = exc_cause;
                end
            end else if (exc_cause !== 2'd0) begin
                o_cause_bad = 1;
            end
            acc = 0;
            if (mem_req_valid) begin
                o_req_seen++;
                if (o_req_seen == 1) begin
                    o_req_cycle = cyc;
                    o_addr = mem_addr;
                end else if (mem_addr !== o_addr) begin
                    o_unstable = 1;
                end
                mem_req_ready = (o_req_seen > req_stall);
                acc = mem_req_ready;
            end else begin
                mem_req_ready = 1'($urandom_range(0, 1));
            end
            if (waiting) begin
                if (cd == 0) begin
                    mem_resp_valid = 1'b1; mem_rdata = w; waiting = 0;
                end else begin
                    cd--; mem_resp_valid = 1'b0; mem_rdata = $urandom;
                end
            end else begin
                mem_resp_valid = 1'($urandom_range(0, 1)); mem_rdata = $urandom;
            end
            if (acc) begin
                waiting = 1; cd = resp_delay;
            end
            if (wb_valid) begin
                o_wb_seen++;
                if (o_wb_seen == 1) begin
                    o_wb_cycle = cyc; o_data = wb_data; o_rd = wb_rd;
                end else if (wb_data !== o_data || wb_rd !== o_rd) begin
                    o_unstable = 1;
                end
                wb_ready = (o_wb_seen > wb_stall);
                if (wb_ready) o_wb_cnt++;
            end else begin
                wb_ready = 1'($urandom_range(0, 1));
            end
            if (cyc == 200) o_timeout = 1;
        end
        in_valid = 1'b0; mem_req_ready = 1'b0; mem_resp_valid = 1'b0; wb_ready = 1'b0;
    endtask

    task automatic test_reset();
        #2;
        checks++;
        if ({in_ready, mem_req_valid, wb_valid, exc_valid, mem_addr, wb_rd, wb_data, exc_cause} !== 75'd0) begin
            errors++;
            $display("FAIL reset_outputs got rdy=%b req=%b wb=%b exc=%b addr=%h rd=%h data=%h cause=%h want all 0",
                     in_ready, mem_req_valid, wb_valid, exc_valid, mem_addr, wb_rd, wb_data, exc_cause);
        end
        @(negedge clk);
        rst = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b0) begin
            errors++; $display("FAIL reset_release_ready_early got %b want 0", in_ready);
        end
        @(posedge clk);
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++; $display("FAIL reset_first_edge_ready got %b want 1", in_ready);
        end
    endtask

    task automatic test_lb_latency();
        run_load(lk_lb, 32'h0000_1003, 5'd7, 32'h80FF_1234, 0, 0, 0);
        checks++; if (o_ready0 !== 1) begin errors++; $display("FAIL lb_ready0 got %0d want 1", o_ready0); end
        checks++; if (o_req_cycle !== 1) begin errors++; $display("FAIL lb_req_cycle got %0d want 1", o_req_cycle); end
        checks++; if (o_addr !== 32'h0000_1000) begin errors++; $display("FAIL lb_mem_addr got %h want 00001000", o_addr); end
        checks++; if (o_wb_cycle !== 3) begin errors++; $display("FAIL lb_wb_cycle got %0d want 3", o_wb_cycle); end
        checks++; if (o_data !== 32'hFFFF_FF80) begin errors++; $display("FAIL lb_wb_data got %h want ffffff80", o_data); end
        checks++; if (o_rd !== 5'd7) begin errors++; $display("FAIL lb_wb_rd got %0d want 7", o_rd); end
        checks++; if (o_ready_cycle !== 4) begin errors++; $display("FAIL lb_ready_cycle got %0d want 4", o_ready_cycle); end
        checks++; if (o_wb_cnt !== 1) begin errors++; $display("FAIL lb_wb_count got %0d want 1", o_wb_cnt); end
    endtask

    task automatic test_halfword();
        run_load(lk_lhu, 32'h0000_2002, 5'd9, 32'hBEEF_0000, 0, 0, 0);
        checks++; if (o_addr !== 32'h0000_2000) begin errors++; $display("FAIL lhu_mem_addr got %h want 00002000", o_addr); end
        checks++; if (o_data !== 32'h0000_BEEF) begin errors++; $display("FAIL lhu_wb_data got %h want 0000beef", o_data); end
        run_load(lk_lh, 32'h0000_2002, 5'd10, 32'hBEEF_0000, 0, 0, 0);
        checks++; if (o_data !== 32'hFFFF_BEEF) begin errors++; $display("FAIL lh_wb_data got %h want ffffbeef", o_data); end
    endtask

    task automatic test_lw_stall();
        run_load(lk_lw, 32'h0000_0010, 5'd31, 32'hA5C3_1E77, 3, 1, 2);
        checks++; if (o_addr !== 32'h0000_0010) begin errors++; $display("FAIL lw_mem_addr got %h want 00000010", o_addr); end
        checks++; if (o_req_seen !== 4) begin errors++; $display("FAIL lw_req_cycles got %0d want 4", o_req_seen); end
        checks++; if (o_wb_seen !== 3) begin errors++; $display("FAIL lw_wb_cycles got %0d want 3", o_wb_seen); end
        checks++; if (o_data !== 32'hA5C3_1E77) begin errors++; $display("FAIL lw_wb_data got %h want a5c31e77", o_data); end
        checks++; if (o_unstable !== 1'b0) begin errors++; $display("FAIL lw_stable got %b want 0", o_unstable); end
        checks++; if (o_wb_cnt !== 1) begin errors++; $display("FAIL lw_wb_count got %0d want 1", o_wb_cnt); end
        checks++; if (o_ready_cycle !== 10) begin errors++; $display("FAIL lw_ready_cycle got %0d want 10", o_ready_cycle); end
    endtask

    task automatic test_illegal();
        run_load(lk_invalid, $urandom, 5'd4, $urandom, 0, 0, 0);
        checks++; if (o_exc_cnt !== 1) begin errors++; $display("FAIL ill_exc_count got %0d want 1", o_exc_cnt); end
        checks++; if (o_exc_cycle !== 1) begin errors++; $display("FAIL ill_exc_cycle got %0d want 1", o_exc_cycle); end
        checks++; if (o_cause !== 2'd0) begin errors++; $display("FAIL ill_cause got %0d want 0", o_cause); end
        checks++; if (o_req_seen !== 0) begin errors++; $display("FAIL ill_mem_req got %0d want 0", o_req_seen); end
        checks++; if (o_wb_seen !== 0) begin errors++; $display("FAIL ill_wb got %0d want 0", o_wb_seen); end
        checks++; if (o_ready_cycle !== 2) begin errors++; $display("FAIL ill_ready_cycle got %0d want 2", o_ready_cycle); end
        checks++; if (o_cause_bad !== 1'b0) begin errors++; $display("FAIL ill_cause_idle got %b want 0", o_cause_bad); end
    endtask

    task automatic test_misaligned();
        logic [31:0] w;
        w = $urandom;
        run_load(lk_lw, 32'h0000_0006, 5'd12, w, 0, 0, 0);
        checks++; if (o_exc_cnt !== (TRAP_EN ? 1 : 0)) begin errors++; $display("FAIL mis_lw_exc got %0d want %0d", o_exc_cnt, TRAP_EN); end
        checks++; if (o_cause !== (TRAP_EN ? 2'd1 : 2'd0)) begin errors++; $display("FAIL mis_lw_cause got %0d want %0d", o_cause, TRAP_EN); end
        checks++; if (o_addr !== (TRAP_EN ? 32'h0 : 32'h4)) begin errors++; $display("FAIL mis_lw_addr got %h want %h", o_addr, TRAP_EN ? 32'h0 : 32'h4); end
        checks++; if (o_data !== (TRAP_EN ? 32'h0 : w)) begin errors++; $display("FAIL mis_lw_data got %h want %h", o_data, TRAP_EN ? 32'h0 : w); end
        checks++; if (o_wb_cnt !== (TRAP_EN ? 0 : 1)) begin errors++; $display("FAIL mis_lw_wb_count got %0d want %0d", o_wb_cnt, TRAP_EN ? 0 : 1); end
        run_load(lk_lh, 32'h0000_0101, 5'd13, 32'h1234_ABCD, 0, 0, 0);
        checks++; if (o_data !== (TRAP_EN ? 32'h0 : 32'hFFFF_ABCD)) begin errors++; $display("FAIL mis_lh_data got %h want %h", o_data, TRAP_EN ? 32'h0 : 32'hFFFF_ABCD); end
    endtask

    task automatic test_reset_mid();
        bit saw_wb, saw_req;
        saw_wb = 0; saw_req = 0;
        @(negedge clk);
        in_valid = 1'b1; in_kind = lk_lw; in_addr = 32'h0000_0040; in_rd = 5'd3;
        mem_req_ready = 1'b1; mem_resp_valid = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        checks++; if (mem_req_valid !== 1'b1) begin errors++; $display("FAIL rstmid_req got %b want 1", mem_req_valid); end
        @(negedge clk);
        mem_req_ready = 1'b0;
        checks++; if ({mem_req_valid, wb_valid, in_ready} !== 3'b000) begin errors++; $display("FAIL rstmid_wait got %b want 000", {mem_req_valid, wb_valid, in_ready}); end
        rst = 1'b0;
        #1;
        checks++;
        if ({in_ready, mem_req_valid, wb_valid, exc_valid, mem_addr, wb_rd, wb_data, exc_cause} !== 75'd0) begin
            errors++;
            $display("FAIL rstmid_outputs got rdy=%b req=%b wb=%b exc=%b addr=%h rd=%h data=%h cause=%h want all 0",
                     in_ready, mem_req_valid, wb_valid, exc_valid, mem_addr, wb_rd, wb_data, exc_cause);
        end
        @(negedge clk);
        rst = 1'b1; mem_resp_valid = 1'b1; mem_rdata = 32'hCAFE_F00D;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (wb_valid) saw_wb = 1;
            if (mem_req_valid) saw_req = 1;
            if (i == 2) mem_resp_valid = 1'b0;
        end
        checks++; if (saw_wb !== 1'b0) begin errors++; $display("FAIL rstmid_no_wb got %b want 0", saw_wb); end
        checks++; if (saw_req !== 1'b0) begin errors++; $display("FAIL rstmid_no_req got %b want 0", saw_req); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rstmid_ready got %b want 1", in_ready); end
        checks++; if (wb_data !== 32'd0) begin errors++; $display("FAIL rstmid_wb_data got %h want 0", wb_data); end
    endtask

    task automatic test_random();
        load_kind_t  k;
        logic [31:0] a, w, exp_d;
        logic [4:0]  rd;
        bit          exp_exc;
        for (int i = 0; i < 40; i++) begin
            k  = ($urandom_range(0, 7) == 0) ? lk_invalid : load_kind_t'(3'($urandom_range(1, 5)));
            a  = $urandom;
            w  = $urandom;
            rd = 5'($urandom);
            run_load(k, a, rd, w, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3));
            exp_exc = (k == lk_invalid) || (TRAP_EN && ref_misaligned(k, a));
            exp_d   = ref_data(k, a, w);
            checks++; if (o_ready0 !== 1 || o_timeout !== 1'b0) begin errors++; $display("FAIL rnd_handshake[%0d] ready0=%0d timeout=%b want 1/0", i, o_ready0, o_timeout); end
            checks++; if (o_unstable !== 1'b0 || o_cause_bad !== 1'b0) begin errors++; $display("FAIL rnd_stable[%0d] unstable=%b cause_bad=%b want 0/0", i, o_unstable, o_cause_bad); end
            if (exp_exc) begin
                checks++; if (o_exc_cnt !== 1) begin errors++; $display("FAIL rnd_exc_count[%0d] got %0d want 1", i, o_exc_cnt); end
                checks++; if (o_cause !== ((k == lk_invalid) ? 2'd0 : 2'd1)) begin errors++; $display("FAIL rnd_cause[%0d] got %0d kind %0d", i, o_cause, k); end
                checks++; if (o_req_seen + o_wb_seen !== 0) begin errors++; $display("FAIL rnd_exc_side[%0d] req=%0d wb=%0d want 0/0", i, o_req_seen, o_wb_seen); end
            end else begin
                checks++; if (o_addr !== (a & 32'hFFFF_FFFC)) begin errors++; $display("FAIL rnd_addr[%0d] got %h want %h", i, o_addr, a & 32'hFFFF_FFFC); end
                checks++; if (o_data !== exp_d) begin errors++; $display("FAIL rnd_data[%0d] kind %0d addr %h word %h got %h want %h", i, k, a, w, o_data, exp_d); end
                checks++; if (o_rd !== rd) begin errors++; $display("FAIL rnd_rd[%0d] got %0d want %0d", i, o_rd, rd); end
                checks++; if (o_wb_cnt !== 1 || o_exc_cnt !== 0) begin errors++; $display("FAIL rnd_wb_count[%0d] wb=%0d exc=%0d want 1/0", i, o_wb_cnt, o_exc_cnt); end
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_lb_latency();
        test_halfword();
        test_lw_stall();
        test_illegal();
        test_misaligned();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
